// File: rtl/apb4_slave_ctrl_if.sv
// APB4 completer-side bus bundle for apb4_slave_ctrl.
interface apb4_slave_ctrl_if #(
   parameter int unsigned ADDRWIDTH = 12
);
   logic                 psel;
   logic                 penable;
   logic                 pwrite;
   logic [ADDRWIDTH-1:0] paddr;
   logic [31:0]          pwdata;
   logic [3:0]           pstrb;
   logic [2:0]           pprot;
   logic                 pready;
   logic [31:0]          prdata;
   logic                 pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb4_slave_ctrl.sv
// APB4 slave front end for the scratch register file and ID window: wait states, strobes, error decode.
// Optional address/direction error decode enabled by defining APB4_SLAVE_CTRL_PSLVERR_EN.
module apb4_slave_ctrl #(
   parameter int unsigned ADDRWIDTH   = 12,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                 pclk,
   input  logic                 preset,
   apb4_slave_ctrl_if.slave     apb,
   output logic [ADDRWIDTH-1:0] addr,
   output logic                 read_en,
   output logic                 write_en,
   output logic [3:0]           byte_strobe,
   output logic [31:0]          wdata,
   input  logic [31:0]          rdata
);
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned DEC_LSB = 12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             wr_q;
   logic             err_q;
   logic             err_c;
   logic             setup_c;
   logic             access_c;
   logic             unused_pprot;

   assign unused_pprot = ^apb.pprot;
   assign setup_c      = apb.psel & ~apb.penable;

`ifdef APB4_SLAVE_CTRL_PSLVERR_EN
   // Reads may hit the scratch words or the ID window; writes only the scratch words.
   logic hi_set_c;
   logic scratch_c;
   logic id_win_c;

   assign hi_set_c  = (apb.paddr >> DEC_LSB) != '0;
   assign scratch_c = apb.paddr[11:4] == 8'h00;
   assign id_win_c  = apb.paddr[11:6] == 6'h3F;
   assign err_c     = hi_set_c | (apb.pwrite ? ~scratch_c : ~(scratch_c | id_win_c));
`else
   assign err_c = 1'b0;
`endif

   // Strobes are qualified live by psel/penable so a malformed ACCESS issues nothing.
   assign access_c    = (state == S_ACCESS) & apb.psel & apb.penable & ~err_q;
   assign write_en    = access_c & wr_q;
   assign read_en     = access_c & ~wr_q;
   assign apb.prdata  = read_en ? rdata : 32'h0;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         addr        <= '0;
         wdata       <= '0;
         byte_strobe <= '0;
         apb.pready  <= 1'b0;
         apb.pslverr <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               apb.pready  <= 1'b0;
               apb.pslverr <= 1'b0;
               if (setup_c) begin
                  addr        <= apb.paddr;
                  wr_q        <= apb.pwrite;
                  wdata       <= apb.pwdata;
                  byte_strobe <= apb.pwrite ? apb.pstrb : 4'b0000;
                  err_q       <= err_c;
                  if (WAIT_CYCLES == 0) begin
                     state       <= S_ACCESS;
                     apb.pready  <= 1'b1;
                     apb.pslverr <= err_c;
                  end else begin
                     cnt   <= CNT_W'(WAIT_CYCLES);
                     state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // A dropped psel abandons the transfer without any strobe.
               if (!apb.psel) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state       <= S_ACCESS;
                     apb.pready  <= 1'b1;
                     apb.pslverr <= err_q;
                  end
               end
            end
            S_ACCESS: begin
               state       <= S_IDLE;
               apb.pready  <= 1'b0;
               apb.pslverr <= 1'b0;
            end
            default: begin
               state       <= S_IDLE;
               apb.pready  <= 1'b0;
               apb.pslverr <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb4_slave_ctrl.sv
// Directed bench: three controllers (0, 3 and 4 wait states) each fronting a small register-file model.
module tb_apb4_slave_ctrl;
`ifdef APB4_SLAVE_CTRL_PSLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        pclk;
   logic        preset;
   logic        rf_clr;
   int          sel;
   logic        psel_d, penable_d, pwrite_d;
   logic [11:0] paddr_d;
   logic [31:0] pwdata_d;
   logic [3:0]  pstrb_d;

   logic [11:0] ra [3];
   logic        re [3];
   logic        we [3];
   logic [3:0]  bs [3];
   logic [31:0] wd [3];
   logic [31:0] rd [3];
   logic [3:0][31:0] rf [3];

   logic        cur_pready, cur_pslverr, cur_re, cur_we;
   logic [31:0] cur_prdata, cur_wdata;
   logic [11:0] cur_addr;
   logic [3:0]  cur_bs;

   int          checks;
   int          errors;
   int          res_cycles, res_we, res_re;
   logic [31:0] res_rdata;
   logic        res_err;
   logic [3:0]  res_bs;
   int          cyc_a;
   int          abort_we;

   apb4_slave_ctrl_if #(.ADDRWIDTH(12)) bus0 ();
   apb4_slave_ctrl_if #(.ADDRWIDTH(12)) bus1 ();
   apb4_slave_ctrl_if #(.ADDRWIDTH(12)) bus2 ();

   assign bus0.psel = psel_d && (sel == 0);
   assign bus1.psel = psel_d && (sel == 1);
   assign bus2.psel = psel_d && (sel == 2);
   assign bus0.penable = penable_d;  assign bus1.penable = penable_d;  assign bus2.penable = penable_d;
   assign bus0.pwrite  = pwrite_d;   assign bus1.pwrite  = pwrite_d;   assign bus2.pwrite  = pwrite_d;
   assign bus0.paddr   = paddr_d;    assign bus1.paddr   = paddr_d;    assign bus2.paddr   = paddr_d;
   assign bus0.pwdata  = pwdata_d;   assign bus1.pwdata  = pwdata_d;   assign bus2.pwdata  = pwdata_d;
   assign bus0.pstrb   = pstrb_d;    assign bus1.pstrb   = pstrb_d;    assign bus2.pstrb   = pstrb_d;
   assign bus0.pprot   = 3'b010;     assign bus1.pprot   = 3'b001;     assign bus2.pprot   = 3'b000;

   apb4_slave_ctrl #(.ADDRWIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .preset(preset), .apb(bus0), .addr(ra[0]), .read_en(re[0]),
      .write_en(we[0]), .byte_strobe(bs[0]), .wdata(wd[0]), .rdata(rd[0]));
   apb4_slave_ctrl #(.ADDRWIDTH(12), .WAIT_CYCLES(3)) u_dut3 (
      .pclk(pclk), .preset(preset), .apb(bus1), .addr(ra[1]), .read_en(re[1]),
      .write_en(we[1]), .byte_strobe(bs[1]), .wdata(wd[1]), .rdata(rd[1]));
   apb4_slave_ctrl #(.ADDRWIDTH(12), .WAIT_CYCLES(4)) u_dut4 (
      .pclk(pclk), .preset(preset), .apb(bus2), .addr(ra[2]), .read_en(re[2]),
      .write_en(we[2]), .byte_strobe(bs[2]), .wdata(wd[2]), .rdata(rd[2]));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Register block model: 4 scratch words at 0x000-0x00C, ID window with 0xFE0 = 0x0D.
   function automatic logic [31:0] rf_read(input logic [3:0][31:0] r, input logic [11:0] a);
      if (a[11:4] == 8'h00) return r[a[3:2]];
      if (a == 12'hFE0)     return 32'h0000000D;
      if (a == 12'hFF0)     return 32'h0000000D;
      return 32'h0;
   endfunction

   always_ff @(posedge pclk) begin
      for (int k = 0; k < 3; k++) begin
         if (rf_clr) rf[k] <= '0;
         else if (we[k] && ra[k][11:4] == 8'h00)
            for (int b = 0; b < 4; b++)
               if (bs[k][b]) rf[k][ra[k][3:2]][8*b +: 8] <= wd[k][8*b +: 8];
      end
   end

   always_comb begin
      for (int k = 0; k < 3; k++) rd[k] = rf_read(rf[k], ra[k]);
   end

   always_comb begin
      cur_pready = bus0.pready;  cur_pslverr = bus0.pslverr; cur_prdata = bus0.prdata;
      cur_re = re[0]; cur_we = we[0]; cur_addr = ra[0]; cur_wdata = wd[0]; cur_bs = bs[0];
      if (sel == 1) begin
         cur_pready = bus1.pready;  cur_pslverr = bus1.pslverr; cur_prdata = bus1.prdata;
         cur_re = re[1]; cur_we = we[1]; cur_addr = ra[1]; cur_wdata = wd[1]; cur_bs = bs[1];
      end else if (sel == 2) begin
         cur_pready = bus2.pready;  cur_pslverr = bus2.pslverr; cur_prdata = bus2.prdata;
         cur_re = re[2]; cur_we = we[2]; cur_addr = ra[2]; cur_wdata = wd[2]; cur_bs = bs[2];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full APB transfer; leaves the bus free at posedge+1 so a caller can chain back-to-back.
   task automatic xfer(input int k, input logic wr, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] s);
      bit done;
      done = 1'b0;
      sel = k; psel_d = 1'b1; penable_d = 1'b0; pwrite_d = wr;
      paddr_d = a; pwdata_d = d; pstrb_d = s;
      res_cycles = 1; res_we = 0; res_re = 0; res_rdata = 'x; res_err = 1'bx; res_bs = 'x;
      @(posedge pclk); #1 penable_d = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge pclk);
         res_cycles++;
         res_we += int'(cur_we);
         res_re += int'(cur_re);
         if (cur_pready) begin
            done = 1'b1;
            res_rdata = cur_prdata; res_err = cur_pslverr; res_bs = cur_bs;
         end
         @(posedge pclk); #1;
      end
      if (!done) chk("pready_timeout", 32'(done), 32'd1);
      psel_d = 1'b0; penable_d = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge pclk); #1; end
   endtask

   initial begin
      checks = 0; errors = 0; sel = 0;
      preset = 1'b1; rf_clr = 1'b1;
      psel_d = 1'b0; penable_d = 1'b0; pwrite_d = 1'b0;
      paddr_d = '0; pwdata_d = '0; pstrb_d = '0;

      // Reset state
      @(negedge pclk);
      chk("rst_pready",  32'(cur_pready), 32'd0);
      chk("rst_pslverr", 32'(cur_pslverr), 32'd0);
      chk("rst_prdata",  cur_prdata, 32'h0);
      chk("rst_strobes", 32'({cur_re, cur_we}), 32'd0);
      chk("rst_latches", 32'({cur_addr, cur_bs} | 16'(cur_wdata != 0)), 32'd0);
      @(negedge pclk); preset = 1'b0; rf_clr = 1'b0;
      @(posedge pclk); #1;

      // Zero wait states: write then read 0x004
      xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
      chk("w0_wr_cycles", 32'(res_cycles), 32'd2);
      chk("w0_wr_we",     32'(res_we), 32'd1);
      chk("w0_wr_err",    32'(res_err), 32'd0);
      idle(2);
      chk("w0_hold_addr",  32'(cur_addr), 32'h004);
      chk("w0_hold_wdata", cur_wdata, 32'hDEADBEEF);
      chk("w0_hold_bs",    32'(cur_bs), 32'hF);
      chk("w0_idle_pready", 32'(cur_pready), 32'd0);
      xfer(0, 1'b0, 12'h004, 32'h0, 4'hF);
      chk("w0_rd_data",   res_rdata, 32'hDEADBEEF);
      chk("w0_rd_err",    32'(res_err), 32'd0);
      chk("w0_rd_re",     32'(res_re), 32'd1);
      chk("w0_rd_bs",     32'(res_bs), 32'h0);
      idle(1);

      // Three wait states: partial-strobe write over all-ones
      xfer(1, 1'b1, 12'h008, 32'hFFFFFFFF, 4'hF);
      idle(1);
      xfer(1, 1'b1, 12'h008, 32'h11223344, 4'b0101);
      chk("w3_wr_cycles", 32'(res_cycles), 32'd5);
      chk("w3_wr_we",     32'(res_we), 32'd1);
      idle(1);
      xfer(1, 1'b0, 12'h008, 32'h0, 4'hF);
      chk("w3_rd_cycles", 32'(res_cycles), 32'd5);
      chk("w3_rd_data",   res_rdata, 32'hFF22FF44);
      chk("w3_rd_bs",     32'(res_bs), 32'h0);
      idle(1);

      // Decode: unmapped write, unmapped read, ID window reads
      xfer(0, 1'b1, 12'hFE0, 32'h12345678, 4'hF);
      chk("dec_wr_err", 32'(res_err), 32'(ERR_EN));
      chk("dec_wr_we",  32'(res_we), ERR_EN ? 32'd0 : 32'd1);
      idle(1);
      xfer(0, 1'b0, 12'h100, 32'h0, 4'h0);
      chk("dec_rd_err",  32'(res_err), 32'(ERR_EN));
      chk("dec_rd_data", res_rdata, 32'h0);
      chk("dec_rd_re",   32'(res_re), ERR_EN ? 32'd0 : 32'd1);
      idle(1);
      xfer(0, 1'b0, 12'hFE0, 32'h0, 4'h0);
      chk("id_rd_data", res_rdata, 32'h0000000D);
      chk("id_rd_err",  32'(res_err), 32'd0);
      chk("id_rd_re",   32'(res_re), 32'd1);
      idle(1);
      xfer(0, 1'b0, 12'hFF0, 32'h0, 4'h0);
      chk("id_ff0_data", res_rdata, 32'h0000000D);
      idle(1);

      // Back-to-back write then read of 0x000
      xfer(0, 1'b1, 12'h000, 32'hCAFE0001, 4'hF);
      cyc_a = res_cycles;
      xfer(0, 1'b0, 12'h000, 32'h0, 4'hF);
      chk("b2b_busy_cycles", 32'(cyc_a + res_cycles), 32'd4);
      chk("b2b_rd_data",     res_rdata, 32'hCAFE0001);
      idle(1);

      // Reset during WAIT of a write to 0x00C
      xfer(2, 1'b1, 12'h00C, 32'hA5A5A5A5, 4'hF);
      chk("w4_wr_cycles", 32'(res_cycles), 32'd6);
      idle(1);
      sel = 2; psel_d = 1'b1; penable_d = 1'b0; pwrite_d = 1'b1;
      paddr_d = 12'h00C; pwdata_d = 32'h12345678; pstrb_d = 4'hF;
      @(posedge pclk); #1 penable_d = 1'b1;
      @(negedge pclk);
      chk("rstw_pre_wdata", cur_wdata, 32'h12345678);
      preset = 1'b1;
      #1;
      chk("rstw_pready",  32'(cur_pready), 32'd0);
      chk("rstw_strobes", 32'({cur_re, cur_we, cur_pslverr}), 32'd0);
      chk("rstw_addr",    32'(cur_addr), 32'd0);
      chk("rstw_wdata",   cur_wdata, 32'h0);
      chk("rstw_bs",      32'(cur_bs), 32'd0);
      @(posedge pclk); #1 psel_d = 1'b0; penable_d = 1'b0;
      @(negedge pclk); preset = 1'b0;
      @(posedge pclk); #1;
      xfer(2, 1'b0, 12'h00C, 32'h0, 4'h0);
      chk("rstw_rd_data", res_rdata, 32'hA5A5A5A5);
      idle(1);

      // psel dropped during WAIT aborts the write
      sel = 1; psel_d = 1'b1; penable_d = 1'b0; pwrite_d = 1'b1;
      paddr_d = 12'h00C; pwdata_d = 32'hBBBBBBBB; pstrb_d = 4'hF;
      abort_we = 0;
      @(posedge pclk); #1 penable_d = 1'b1;
      @(negedge pclk); abort_we += int'(cur_we);
      @(posedge pclk); #1 psel_d = 1'b0; penable_d = 1'b0;
      repeat (6) begin
         @(negedge pclk);
         abort_we += int'(cur_we) + int'(cur_pready);
      end
      @(posedge pclk); #1;
      chk("abort_no_we", 32'(abort_we), 32'd0);
      xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0);
      chk("abort_rd_data", res_rdata, 32'h0);
      idle(1);
      xfer(1, 1'b1, 12'h00C, 32'h55AA55AA, 4'hF);
      chk("post_abort_cycles", 32'(res_cycles), 32'd5);
      chk("post_abort_we",     32'(res_we), 32'd1);
      idle(1);
      xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0);
      chk("post_abort_rd", res_rdata, 32'h55AA55AA);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb4_slave_ctrl.md
# apb4_slave_ctrl

APB4 slave front-end controller that sequences the 4-word scratch register file plus its ID/CID read-only window. It runs the APB4 SETUP/ACCESS handshake, inserts a programmable number of wait states, and generates single-cycle `read_en`/`write_en` strobes toward the register block. It also decodes unmapped and illegal accesses into `pslverr`. It sits between the APB4 interconnect and the register block, which has no protocol logic of its own.

## Interface
Parameters:
- `ADDRWIDTH`, 12, APB address width; must be ≥ 12; decode uses `paddr[11:2]`, and any set bit above bit 11 marks the access unmapped.
- `WAIT_CYCLES`, 0, wait states inserted before ACCESS; legal range 0–15.

Ports:
- `pclk`  in  1  clock; all logic on rising edge.
- `preset`  in  1  reset, asynchronous, active-high.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable.
- `pwrite`  in  1  1 = write.
- `paddr`  in  ADDRWIDTH  byte address.
- `pwdata`  in  32  write data.
- `pstrb`  in  4  write byte strobes.
- `pprot`  in  3  accepted and ignored.
- `pready`  out  1  transfer complete.
- `prdata`  out  32  read data.
- `pslverr`  out  1  error response.
- `addr`  out  ADDRWIDTH  register-block address, latched at SETUP.
- `read_en`  out  1  register-block read strobe.
- `write_en`  out  1  register-block write strobe.
- `byte_strobe`  out  4  register-block byte lanes.
- `wdata`  out  32  register-block write data, latched at SETUP.
- `rdata`  in  32  register-block combinational read data.

## Operation
- FSM states: IDLE, WAIT, ACCESS. Reset state is IDLE.
- **IDLE:**
  - On `psel & ~penable` (setup phase): latch `paddr`, `pwrite`, `pwdata`, and `pstrb` (forced to 4'b0 when `pwrite`=0). Compute the error flag.
  - If `WAIT_CYCLES`=0, go to ACCESS. Otherwise load a 4-bit counter with `WAIT_CYCLES` and go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle; when it reaches 1, go to ACCESS.
  - If `psel`=0 (aborted transfer), go to IDLE with no strobe issued.
- **ACCESS:**
  - `pready`=1 for exactly one cycle, then IDLE unconditionally.
  - `write_en` = latched write & ~err & `psel` & `penable`.
  - `read_en` = latched read & ~err & `psel` & `penable`.
  - `prdata` = `rdata` when `read_en`, otherwise 0.
  - `pslverr` = err.
- Outside ACCESS: `pready`, `read_en`, `write_en`, `pslverr` = 0 and `prdata` = 0.
- `addr`, `wdata`, `byte_strobe` hold their latched values until the next SETUP.
- Error decode (only with macro):
  - Read is legal if `paddr[11:4]`=0 or `paddr[11:6]`=6'h3F.
  - Write is legal only if `paddr[11:4]`=0.
  - Anything else is an error, and no strobe is issued.
- Back-to-back transfers: the SETUP of the next transfer coincides with the IDLE cycle after ACCESS. This adds no extra bubble.

## Timing
- Latency: SETUP cycle, then `WAIT_CYCLES` cycles with `pready`=0, then the ACCESS cycle with `pready`=1. Total is `WAIT_CYCLES`+2 cycles per transfer.
- Register write commits on the rising edge that ends ACCESS, the same edge where the APB transfer completes.
- Read data is combinational through `rdata` in the ACCESS cycle; there is no extra register stage.
- Reset values: all outputs 0; state IDLE; counter 0.
- Assertion of `preset` mid-transfer immediately forces IDLE and zero outputs. No write is issued, and the transfer is lost.
- `penable` low in ACCESS (protocol violation): no strobe, `pready` still pulses, then IDLE.

## Configuration
- `APB4_SLAVE_CTRL_PSLVERR_EN` defined: address/direction decode is active as above; illegal accesses return `pslverr`=1, `prdata`=0, and issue no strobe.
- Not defined:
  - `pslverr` is tied 0 and the decode logic is removed.
  - Every access is forwarded to the register block.
  - Unmapped writes are discarded by the register block; unmapped reads return whatever `rdata` supplies (0).

## Test plan
- `WAIT_CYCLES`=0, write 0xDEADBEEF, `pstrb`=4'hF, to 0x004, then read 0x004. Write completes in 2 cycles; `write_en` is high for exactly 1 cycle; the read returns 0xDEADBEEF with `pslverr`=0.
- `WAIT_CYCLES`=3, write 0x11223344 with `pstrb`=4'b0101 to 0x008 over prior 0xFFFFFFFF, then read back. `pready` goes high in cycle 5; the read returns 0xFF22FF44; `byte_strobe`=0 during the read.
- With macro: write to 0xFE0, then read 0x100. Both get `pslverr`=1 and `prdata`=0, with no `write_en`/`read_en`. A read of 0xFE0 returns 0x0000000D with `pslverr`=0.
- Back-to-back: write 0x000 then immediately read 0x000, with `WAIT_CYCLES`=0. There are 4 consecutive busy cycles with no idle gap, and the read returns the new value.
- Assert `preset` in the WAIT state of a write to 0x00C (`WAIT_CYCLES`=4). All outputs drop to 0 asynchronously, and 0x00C still reads its previous value after reset release.
- Drop `psel` during WAIT. The FSM returns to IDLE and `write_en` never asserts; the next normal transfer completes correctly.
